scaler_v: RTL

Vertical linear-interpolation downscaler, placed directly after `scaler_h` in the scaler pipeline. It takes the horizontally scaled pixel stream (`do_o/de_o/hs_o/vs_o` of `scaler_h`) and keeps one line buffer holding the previous input line. While each new input line streams in, it emits at most one output line, blended from the buffered line and the current line. Pixel order and `de` gaps within a line are preserved. Ratios from 1.0 (pass-through) to 16.0 are supported.

---
 rtl/scaler_v.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/scaler_v.sv
// Vertical linear-interpolation downscaler with one previous-line buffer.
// Define SCALER_V_ROUND_EN to round the blend half up instead of truncating.
module scaler_v #(
  parameter int PIXEL_STEP    = 4096,
  parameter int PIXEL_WIDTH   = 8,
  parameter int COE_WIDTH     = 10,
  parameter int MAX_LINE_SIZE = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            scale_step,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int F  = $clog2(PIXEL_STEP);
  localparam int C  = COE_WIDTH;
  localparam int PW = PIXEL_WIDTH;
  localparam int SW = PW + C + 1;
  localparam int AW = $clog2(MAX_LINE_SIZE);
  localparam int XW = AW + 1;

  localparam logic [23:0]   ONE   = 24'(PIXEL_STEP);
  localparam logic [15:0]   ONE16 = 16'(PIXEL_STEP);
  localparam logic [XW-1:0] XMAX  = XW'(MAX_LINE_SIZE);
  localparam logic [C:0]    FULL  = (C+1)'(1) << C;

`ifdef SCALER_V_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (C - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FIRST = 2'd1;
  localparam logic [1:0] LINE  = 2'd2;

  logic [1:0]    state;
  logic [23:0]   pos;
  logic [23:0]   lim;
  logic [15:0]   step;
  logic [XW-1:0] x;
  logic          emit_q;
  logic          vs_pend;
  logic [C-1:0]  coe_q;

  logic          frame_hs;
  logic          line_hs;
  logic          emit_n;
  logic [C-1:0]  coe_n;
  logic [15:0]   step_n;
  logic [AW-1:0] addr;
  logic          in_rng;
  logic          wr;

  assign frame_hs = hs_i & vs_i;
  assign line_hs  = hs_i & ~vs_i & (state != IDLE);
  assign emit_n   = pos < lim;
  assign coe_n    = C'((pos - (lim - ONE)) >> (F - C));
  assign step_n   = (scale_step < ONE16) ? ONE16 : scale_step;
  assign addr     = x[AW-1:0];
  assign in_rng   = x < XMAX;
  assign wr       = de_i & in_rng & (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pos     <= '0;
      lim     <= '0;
      step    <= '0;
      emit_q  <= 1'b0;
      vs_pend <= 1'b0;
      coe_q   <= '0;
    end else if (frame_hs) begin
      state   <= FIRST;
      pos     <= '0;
      lim     <= ONE;
      step    <= step_n;
      emit_q  <= 1'b0;
      vs_pend <= 1'b1;
      coe_q   <= '0;
    end else if (line_hs) begin
      state   <= LINE;
      lim     <= lim + ONE;
      emit_q  <= emit_n;
      vs_pend <= vs_pend & ~emit_n;
      if (emit_n) begin
        coe_q <= coe_n;
        pos   <= pos + 24'(step);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      x <= '0;
    else if (hs_i)
      x <= '0;
    else if (de_i && x != XMAX)
      x <= x + 1'b1;
  end

  // Read-first line buffer: A is the previous line at the same x.
  logic [PW-1:0] mem [MAX_LINE_SIZE];
  logic [PW-1:0] a_ram;

  always_ff @(posedge clk) begin
    a_ram <= mem[addr];
    if (wr)
      mem[addr] <= di_i;
  end

  logic          de1, hs1, vs1, inr1;
  logic [PW-1:0] b1;
  logic [C-1:0]  c1;
  logic [PW-1:0] a1;
  logic [C:0]    wa;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1  <= 1'b0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      inr1 <= 1'b0;
      b1   <= '0;
      c1   <= '0;
    end else begin
      de1  <= de_i & emit_q & ~hs_i;
      hs1  <= line_hs & emit_n;
      vs1  <= line_hs & emit_n & vs_pend;
      inr1 <= in_rng;
      b1   <= di_i;
      c1   <= coe_q;
    end
  end

  assign a1 = inr1 ? a_ram : '0;
  assign wa = FULL - {1'b0, c1};

  logic          de2, hs2, vs2;
  logic [SW-1:0] pa, pb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de2 <= 1'b0;
      hs2 <= 1'b0;
      vs2 <= 1'b0;
      pa  <= '0;
      pb  <= '0;
    end else begin
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      pa  <= SW'(a1) * SW'(wa);
      pb  <= SW'(b1) * SW'(c1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      de_o <= de2;
      hs_o <= hs2;
      vs_o <= vs2;
      do_o <= de2 ? PW'((pa + pb + RND) >> C) : '0;
    end
  end

endmodule
